// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the serial adder controller: FSM encoding and digit width.
package serial_adder_ctrl_pkg;

    // Bits consumed per cycle by the shared adder slice.
    localparam int DIGIT = 2;

    // Controller states. The encoding is fixed so debug probes can decode it directly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_full_adder.sv
// Two-bit ripple adder slice shared by the serial controller: sum and carry of a + b + cin.
module full_adder
    import serial_adder_ctrl_pkg::*;
(
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout
);

    logic [DIGIT:0] w_total;

    // Operands are zero-extended so the carry lands in the extra top bit.
    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};
    assign o_sum   = w_total[DIGIT-1:0];
    assign o_cout  = w_total[DIGIT];

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Serial add/subtract controller. It feeds one 2-bit adder slice LSB digit first and chains
// the carry through a register, so a WIDTH-bit result takes WIDTH/2 cycles.
// WIDTH must be even and at least 4.
module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf
);

    import serial_adder_ctrl_pkg::*;

    localparam int                N     = WIDTH / DIGIT;
    localparam int                CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

    state_t             r_state;
    state_t             w_next_state;

    // Operand shift registers: the low digit of each feeds the slice.
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    // Holds the digits produced so far. The newest digit is not stored here; it is
    // concatenated on top, so only N-1 digits need storage.
    logic [WIDTH-DIGIT-1:0] r_sum_sr;
    logic                   r_carry;
    logic [CNT_W-1:0]       r_cnt;
    // Operand sign bits as latched. Overflow is judged against these after the
    // operands have been shifted away.
    logic                   r_msb_a;
    logic                   r_msb_b;

    logic                   w_accept;
    logic                   w_last;
    logic [WIDTH-1:0]       w_b_eff;
    logic [DIGIT-1:0]       w_slice_sum;
    logic                   w_slice_cout;
    logic [WIDTH-1:0]       w_sum_full;

    // Subtraction is A + ~B + 1, so B is inverted on the way in.
    assign w_b_eff    = i_sub ? ~i_b : i_b;
    assign w_last     = (r_cnt == LAST);
    assign w_sum_full = {w_slice_sum, r_sum_sr};

    assign o_busy = (r_state == ST_RUN);
    assign o_done = (r_state == ST_DONE);

    full_adder u_slice (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: clocked state uses non-blocking assignments, so every flop samples
        // pre-edge values no matter how the always blocks are ordered.
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and start acceptance. Start is ignored while RUN.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path
        // leaves a signal unassigned and infers a latch.
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_RUN;
                    w_accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_next_state = ST_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch on accept, process one digit per RUN cycle, publish on the last digit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_msb_a  <= 1'b0;
            r_msb_b  <= 1'b0;
            o_sum    <= '0;
            o_carry  <= 1'b0;
            o_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_a;
            r_b      <= w_b_eff;
            r_sum_sr <= '0;
            r_carry  <= i_sub ? 1'b1 : i_carry;
            r_cnt    <= '0;
            r_msb_a  <= i_a[WIDTH-1];
            r_msb_b  <= w_b_eff[WIDTH-1];
            o_sum    <= '0;
            o_carry  <= 1'b0;
            o_ovf    <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_sum_sr <= w_sum_full[WIDTH-1:DIGIT];
            r_carry  <= w_slice_cout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                o_sum   <= w_sum_full;
                o_carry <= w_slice_cout;
                o_ovf   <= (r_msb_a == r_msb_b) && (w_sum_full[WIDTH-1] != r_msb_a);
            end
        end
    end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=16.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             i_rst;
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_carry;
    logic             i_sub;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_ovf;

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_carry (i_carry),
        .i_sub   (i_sub),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
        .o_carry (o_carry),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the DUT never lets the sequence finish.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with a one-cycle start pulse.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub);
        i_a     = a;
        i_b     = b;
        i_carry = cin;
        i_sub   = sub;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Full transaction: latency, result, done width, result hold into IDLE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] exp_sum, input logic exp_c, input logic exp_v);
        int nb;
        start_op(a, b, cin, sub);
        check({tag, "_busy_start"}, 32'(o_busy), 32'd1);
        nb = 0;
        while (o_busy && nb < 20) begin
            nb++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
        check({tag, "_done"}, 32'(o_done), 32'd1);
        check({tag, "_sum"}, 32'(o_sum), 32'(exp_sum));
        check({tag, "_carry"}, 32'(o_carry), 32'(exp_c));
        check({tag, "_ovf"}, 32'(o_ovf), 32'(exp_v));
        tick();
        check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        check({tag, "_sum_hold"}, 32'(o_sum), 32'(exp_sum));
    endtask

    initial begin
        int  n;
        logic seen;

        i_rst   = 1'b1;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_carry = 1'b0;
        i_sub   = 1'b0;

        // Reset for two cycles.
        tick();
        tick();
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_done",  32'(o_done),  32'd0);
        check("rst_sum",   32'(o_sum),   32'd0);
        check("rst_carry", 32'(o_carry), 32'd0);
        check("rst_ovf",   32'(o_ovf),   32'd0);
        i_rst = 1'b0;
        tick();

        // Directed arithmetic vectors.
        run_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_noborrow",16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Start held through part of RUN with different operands must be ignored.
        i_a     = 16'h1234;
        i_b     = 16'h4321;
        i_carry = 1'b0;
        i_sub   = 1'b0;
        i_start = 1'b1;
        tick();
        i_a = 16'hAAAA;
        i_b = 16'h1111;
        for (int i = 0; i < 4; i++) tick();
        i_start = 1'b0;
        n = 0;
        while (o_busy && n < 20) begin
            n++;
            tick();
        end
        check("hold_done", 32'(o_done), 32'd1);
        check("hold_sum",  32'(o_sum),  32'h5555);

        // Back-to-back start during DONE.
        i_a     = 16'h0001;
        i_b     = 16'h0001;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("b2b_busy",      32'(o_busy), 32'd1);
        check("b2b_sum_clear", 32'(o_sum),  32'd0);
        n = 1;
        while (!o_done && n < 40) begin
            n++;
            tick();
        end
        check("b2b_spacing", 32'(n),      32'd9);
        check("b2b_sum",     32'(o_sum),  32'h0002);
        tick();

        // Reset in the third RUN cycle aborts the operation.
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        tick();
        check("abort_in_run", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("abort_busy",  32'(o_busy),  32'd0);
        check("abort_done",  32'(o_done),  32'd0);
        check("abort_sum",   32'(o_sum),   32'd0);
        check("abort_carry", 32'(o_carry), 32'd0);
        check("abort_ovf",   32'(o_ovf),   32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (o_done || o_busy) seen = 1'b1;
            tick();
        end
        check("abort_no_done", 32'(seen), 32'd0);

        run_op("after_abort", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
